uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter BIT_WIDTH, default 8, giving the UART data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum clk cycles to wait for uart_busy to rise.
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port req, input, NUM_REQ, with one level request per requester.
REQ-007 The block SHALL have port req_data, input, NUM_REQ*BIT_WIDTH, where requester i owns bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-008 The block SHALL have port gnt, output, NUM_REQ, a one-hot one-cycle pulse when that requester's byte is accepted.
REQ-009 The block SHALL have port uart_send, output, 1, the send strobe to the UART.
REQ-010 The block SHALL have port uart_tx_data, output, BIT_WIDTH, the byte presented to the UART tx_reg.
REQ-011 The block SHALL have port uart_busy, input, 1, the UART busy flag, already synchronised to clk.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The block SHALL have port timeout_err, output, 1, a one-cycle pulse on a busy-rise timeout.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with any req bit high, the block SHALL, in the same cycle, select a winner round-robin starting at last_grant+1 (modulo NUM_REQ) and pulse gnt[winner].
REQ-016 On the edge ending that IDLE cycle, the block SHALL register uart_tx_data from req_data[winner], set uart_send=1, set last_grant=winner, and enter WAIT_BUSY.
REQ-017 In WAIT_BUSY, uart_send and uart_tx_data SHALL stay constant; on the first cycle uart_busy=1, the block SHALL clear uart_send and enter WAIT_DONE.
REQ-018 In WAIT_DONE, when uart_busy=0, the block SHALL enter IDLE; arbitration SHALL be possible in the next cycle.
REQ-019 uart_tx_data SHALL hold its value outside WAIT_BUSY (no change until the next grant).
REQ-020 With req all zero in IDLE, the block SHALL hold the state and keep gnt=0 and uart_send=0.
REQ-021 A requester SHALL be granted at most once per transfer; if req stays high it SHALL compete again only after the return to IDLE.
REQ-022 If every req bit is high continuously, grants SHALL rotate 0,1,2,...,NUM_REQ-1,0 with no starvation.
REQ-023 Changes on req or req_data after the grant SHALL NOT affect the byte in flight.
REQ-024 If uart_busy is already 1 on entry to WAIT_BUSY, the block SHALL still transition on the first observed cycle with uart_busy=1.
REQ-025 Minimum grant-to-grant spacing SHALL be 3 clk cycles (IDLE, WAIT_BUSY, WAIT_DONE).

Reset
REQ-026 While rst=1 at a clk edge, the block SHALL set state=IDLE, gnt=0, uart_send=0, uart_tx_data=0, busy=0, timeout_err=0, the timeout counter to 0, and last_grant=NUM_REQ-1, so that requester 0 has first priority.
REQ-027 Reset asserted mid-transfer SHALL abort immediately, with no gnt pulse and uart_send=0 on the following cycle.

Configuration
REQ-028 With macro UART_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_BUSY; on reaching TIMEOUT_CYCLES-1 without uart_busy=1, the block SHALL clear uart_send, pulse timeout_err for one cycle, and return to IDLE with last_grant unchanged.
REQ-029 Without UART_ARB_TIMEOUT_EN, no counter SHALL be built, timeout_err SHALL be tied to 0, and WAIT_BUSY SHALL wait indefinitely.

Verification
REQ-030 The bench SHALL cover: req=4'b0100, req_data[2]=8'hA5, UART model raises busy 3 cycles after send for 10 cycles -> gnt=4'b0100 for one cycle, uart_tx_data=8'hA5, uart_send high exactly until busy seen, busy low 1 cycle after uart_busy falls.
REQ-031 The bench SHALL cover: req=4'b1111 held for 8 transfers after reset -> grant order 0,1,2,3,0,1,2,3.
REQ-032 The bench SHALL cover: req=4'b1010 with last_grant=1 -> gnt to requester 3, then requester 1.
REQ-033 The bench SHALL cover: rst pulsed during WAIT_DONE with req=4'b0001 held -> uart_send=0 and busy=0 the next cycle, and requester 0 regranted on the first IDLE cycle after reset.
REQ-034 The bench SHALL cover: with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, uart_busy tied 0 and req=4'b0001 -> timeout_err pulses once 16 cycles after the send rises, and the block returns to IDLE.
REQ-035 The bench SHALL cover: req_data[0] changed from 8'h11 to 8'h22 one cycle after gnt[0] -> uart_tx_data stays 8'h11 for the whole transfer.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte requesters.
// Build option: define UART_ARB_TIMEOUT_EN to add the busy-rise timeout counter.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BIT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  output logic                         uart_send,
  output logic [BIT_WIDTH-1:0]         uart_tx_data,
  input  logic                         uart_busy,
  output logic                         busy,
  output logic                         timeout_err,
  output logic [1:0]                   state_dbg
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 send_q, send_d;
  logic [BIT_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 terr_q, terr_d;

  logic                 winner_found;
  logic [IDX_W-1:0]     winner_idx;
  logic [IDX_W-1:0]     cand;
  logic [BIT_WIDTH-1:0] sel_data;
  logic                 grant_fire;

  // Search starts one past the last winner so a requester held high yields to the others.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    cand         = last_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!winner_found && req[cand]) begin
        winner_found = 1'b1;
        winner_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_idx == IDX_W'(i)) begin
        sel_data = req_data[i*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Reset suppresses the grant so an aborted cycle never reports an accepted byte.
  assign grant_fire = (state_q == ST_IDLE) && winner_found && !rst;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = grant_fire && (winner_idx == IDX_W'(i));
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Handshake: uart_send stays high with uart_tx_data stable until the UART answers
  // with uart_busy=1; the transfer ends when uart_busy falls back to 0.
  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    data_d  = data_q;
    last_d  = last_q;
    terr_d  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (winner_found) begin
          data_d  = sel_data;
          send_d  = 1'b1;
          last_d  = winner_idx;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (uart_busy) begin
          send_d  = 1'b0;
          state_d = ST_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          send_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!uart_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      send_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      data_q  <= data_d;
      last_q  <= last_d;
      terr_q  <= terr_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign uart_send    = send_q;
  assign uart_tx_data = data_q;
  assign busy         = (state_q != ST_IDLE);
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transfer-level model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic           uart_busy = 1'b0;
  logic [N-1:0]   gnt;
  logic           uart_send;
  logic [W-1:0]   uart_tx_data;
  logic           busy;
  logic           timeout_err;
  logic [1:0]     state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .BIT_WIDTH(W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .uart_send(uart_send),
    .uart_tx_data(uart_tx_data),
    .uart_busy(uart_busy),
    .busy(busy),
    .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: one byte in flight at a time, acknowledged by busy rising.
  logic         m_active = 1'b0;
  logic         m_seen   = 1'b0;
  logic         m_terr   = 1'b0;
  logic [W-1:0] m_byte   = '0;
  int           m_last   = N - 1;
  int           m_wait   = 0;

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin : model
    int w;
    if (rst) begin
      m_active <= 1'b0;
      m_seen   <= 1'b0;
      m_terr   <= 1'b0;
      m_byte   <= '0;
      m_last   <= N - 1;
      m_wait   <= 0;
    end else begin
      m_terr <= 1'b0;
      if (!m_active) begin
        w = pick(req, m_last);
        if (w >= 0) begin
          m_active <= 1'b1;
          m_seen   <= 1'b0;
          m_wait   <= 0;
          m_last   <= w;
          m_byte   <= req_data[w*W +: W];
        end
      end else if (!m_seen) begin
        if (uart_busy) m_seen <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
        else if (m_wait == TO - 1) begin
          m_active <= 1'b0;
          m_terr   <= 1'b1;
        end else m_wait <= m_wait + 1;
`endif
      end else if (!uart_busy) begin
        m_active <= 1'b0;
      end
    end
  end

  logic         chk_en = 1'b0;
  int           send_hi = 0;
  logic [7:0]   gnt_log[$];
  logic [7:0]   exp_q[$];

  always @(negedge clk) begin
    if (chk_en) begin : compare
      logic [N-1:0] g_exp;
      int w;
      g_exp = '0;
      if (!m_active && !rst) begin
        w = pick(req, m_last);
        if (w >= 0) g_exp[w] = 1'b1;
      end
      chk("gnt", 32'(gnt), 32'(g_exp));
      chk("uart_send", 32'(uart_send), 32'(m_active && !m_seen));
      chk("uart_tx_data", 32'(uart_tx_data), 32'(m_byte));
      chk("busy", 32'(busy), 32'(m_active));
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      if (uart_send) send_hi++;
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) gnt_log.push_back(8'(i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // UART responder: busy rises d cycles after send is seen and stays high len cycles.
  task automatic uart_xfer(input int d, input int len);
    int n;
    n = 0;
    while (uart_send !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (uart_send !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_wait: uart_send never rose within 50 cycles at %0t", $time);
      return;
    end
    repeat (d) tick();
    uart_busy = 1'b1;
    repeat (len) tick();
    uart_busy = 1'b0;
  endtask

  task automatic check_order(input string name);
    chk({name, "_count"}, 32'(gnt_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++) begin
      chk(name, 32'(gnt_log[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_send", 32'(uart_send), 32'd0);
    chk("reset_tx_data", 32'(uart_tx_data), 32'd0);
    chk("reset_terr", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("idle_no_req_gnt", 32'(gnt), 32'd0);

    // Single requester 2 with byte A5, busy 3 cycles after send for 10 cycles.
    req_data[2*W +: W] = 8'hA5;
    req = 4'b0100;
    send_hi = 0;
    #1;
    chk("single_gnt", 32'(gnt), 32'h4);
    tick();
    req = 4'b0000;
    uart_xfer(3, 10);
    chk("single_busy_held", 32'(busy), 32'd1);
    chk("single_tx_data", 32'(uart_tx_data), 32'hA5);
    tick();
    chk("single_busy_drop", 32'(busy), 32'd0);
    chk("single_send_cycles", 32'(send_hi), 32'd4);

    // uart_busy already high when the byte is launched.
    uart_busy = 1'b1;
    req = 4'b0001;
    send_hi = 0;
    tick();
    req = 4'b0000;
    repeat (3) tick();
    uart_busy = 1'b0;
    repeat (2) tick();
    chk("early_busy_send_cycles", 32'(send_hi), 32'd1);
    chk("early_busy_done", 32'(busy), 32'd0);

    // All requesting from reset: strict rotation.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    gnt_log.delete();
    req = 4'b1111;
    for (int t = 0; t < 8; t++) uart_xfer(1, 2);
    req = 4'b0000;
    repeat (3) tick();
    exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3};
    check_order("rotate_order");

    // Make requester 1 the last winner, then 1010 must go 3 then 1.
    gnt_log.delete();
    req = 4'b0010;
    uart_xfer(1, 2);
    req = 4'b1010;
    uart_xfer(1, 2);
    uart_xfer(1, 2);
    req = 4'b0000;
    repeat (3) tick();
    exp_q = '{8'd1, 8'd3, 8'd1};
    check_order("rr_1010_order");

    // Reset during WAIT_DONE with requester 0 held.
    req = 4'b0001;
    tick();
    uart_busy = 1'b1;
    tick();
    chk("pre_reset_in_flight", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    uart_busy = 1'b0;
    #1;
    chk("abort_send", 32'(uart_send), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_regrant", 32'(gnt), 32'h1);
    tick();
    req = 4'b0000;
    uart_xfer(1, 2);
    repeat (3) tick();

    // Data changed after the grant must not reach the byte in flight.
    req_data[0 +: W] = 8'h11;
    req = 4'b0001;
    tick();
    req_data[0 +: W] = 8'h22;
    req = 4'b0000;
    uart_xfer(2, 3);
    chk("late_data_in_flight", 32'(uart_tx_data), 32'h11);
    repeat (3) tick();
    chk("late_data_held_idle", 32'(uart_tx_data), 32'h11);

`ifdef UART_ARB_TIMEOUT_EN
    // No busy response: timeout fires 16 cycles after send rises.
    uart_busy = 1'b0;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("timeout_delay", 32'(n), 32'd16);
    chk("timeout_idle", 32'(busy), 32'd0);
    chk("timeout_send_clear", 32'(uart_send), 32'd0);
    tick();
    chk("timeout_pulse_end", 32'(timeout_err), 32'd0);
`else
    // No busy response: the arbiter keeps waiting.
    uart_busy = 1'b0;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    repeat (40) tick();
    chk("no_timeout_busy", 32'(busy), 32'd1);
    chk("no_timeout_send", 32'(uart_send), 32'd1);
    uart_xfer(0, 2);
    repeat (2) tick();
    chk("no_timeout_done", 32'(busy), 32'd0);
`endif

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
